// File: rtl/one_digit_counter_if.sv
// Digit-side bus of a one_digit_counter: increment/clear requests in,
// registered digit value and wrap pulse out.
interface one_digit_counter_if #(
    parameter int W = 4
);
    logic         inc;
    logic         clr;
    logic [W-1:0] d;
    logic         carry;

    modport master (output inc, output clr, input d, input carry);
    modport slave  (input inc, input clr, output d, output carry);
endinterface

// File: rtl/one_digit_counter.sv
// Single modulo-(MAX+1) digit with a one-cycle carry pulse on wrap; chains
// into multi-digit counters by feeding carry into the next digit's inc.
module one_digit_counter #(
    parameter int MAX       = 9,
    parameter int W         = 4,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    one_digit_counter_if.slave    bus
);

    if (MAX < 0 || MAX > (2 ** W) - 1) begin : g_max_check
        $error("one_digit_counter: MAX does not fit in W bits");
    end

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] d_q;
    logic [W-1:0] d_nxt;
    logic         carry_q;
    logic         carry_nxt;
    logic         inc_q;
    logic         ev;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        d_nxt     = d_q;
        carry_nxt = 1'b0;
        ev        = EDGE_MODE ? (bus.inc & ~inc_q) : bus.inc;

        if (bus.clr) begin
            d_nxt = '0;
        end else if (ev) begin
            if (d_q == MAX_V) begin
                d_nxt     = '0;
                carry_nxt = 1'b1;
            end else if (d_q > MAX_V) begin
                // Out-of-range value (upset): recover to 0 without a carry.
                d_nxt = '0;
            end else begin
                d_nxt = d_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            d_q     <= '0;
            carry_q <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            d_q     <= d_nxt;
            carry_q <= carry_nxt;
            inc_q   <= bus.inc;
        end
    end

    assign bus.d     = d_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_one_digit_counter.sv
// Self-checking bench: six digits (incl. a two-digit cascade) driven by directed
// and random stimulus, compared each cycle against a modulo-count model.
module tb_one_digit_counter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    one_digit_counter_if #(.W(4)) if0 ();
    one_digit_counter_if #(.W(4)) if1 ();
    one_digit_counter_if #(.W(4)) if2 ();
    one_digit_counter_if #(.W(4)) if3 ();
    one_digit_counter_if #(.W(4)) if4 ();
    one_digit_counter_if #(.W(4)) if5 ();

    one_digit_counter #(.MAX(9), .W(4), .EDGE_MODE(1'b0)) u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    one_digit_counter #(.MAX(5), .W(4), .EDGE_MODE(1'b1)) u1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
    one_digit_counter #(.MAX(3), .W(4), .EDGE_MODE(1'b0)) u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
    one_digit_counter #(.MAX(9), .W(4), .EDGE_MODE(1'b0)) u3 (.clk(clk), .rstn(rstn), .bus(if3.slave));
    one_digit_counter #(.MAX(2), .W(4), .EDGE_MODE(1'b0)) u4 (.clk(clk), .rstn(rstn), .bus(if4.slave));
    one_digit_counter #(.MAX(0), .W(4), .EDGE_MODE(1'b0)) u5 (.clk(clk), .rstn(rstn), .bus(if5.slave));

    // Low digit's wrap pulse is the high digit's increment.
    assign if4.inc = if3.carry;

    int vectors     = 0;
    int miscompares = 0;

    int mx [6] = '{9, 5, 3, 9, 2, 0};
    bit em [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bit inc_v [6];
    bit clr_v [6];
    int cnt   [6];
    bit exp_c [6];
    bit prev  [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        if0.inc = inc_v[0]; if0.clr = clr_v[0];
        if1.inc = inc_v[1]; if1.clr = clr_v[1];
        if2.inc = inc_v[2]; if2.clr = clr_v[2];
        if3.inc = inc_v[3]; if3.clr = clr_v[3];
        if4.clr = clr_v[4];
        if5.inc = inc_v[5]; if5.clr = clr_v[5];
    endtask

    task automatic set_all(input bit inc, input bit clr);
        for (int i = 0; i < 6; i++) begin
            inc_v[i] = inc;
            clr_v[i] = clr;
        end
    endtask

    // Reference: digit value is the number of accepted events since the last
    // clear/reset, taken modulo (MAX+1); a carry marks an event that lands on 0.
    task automatic model_edge();
        bit ci [6];
        bit ev;
        for (int i = 0; i < 6; i++) ci[i] = (i == 4) ? exp_c[3] : inc_v[i];
        for (int i = 0; i < 6; i++) begin
            if (!rstn) begin
                cnt[i] = 0; exp_c[i] = 1'b0; prev[i] = 1'b0;
            end else begin
                ev      = em[i] ? (ci[i] && !prev[i]) : ci[i];
                prev[i] = ci[i];
                if (clr_v[i]) begin
                    cnt[i] = 0; exp_c[i] = 1'b0;
                end else if (ev) begin
                    cnt[i]   = (cnt[i] + 1) % (mx[i] + 1);
                    exp_c[i] = (cnt[i] == 0);
                end else begin
                    exp_c[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] od [6];
        logic       oc [6];
        od[0] = if0.d; oc[0] = if0.carry;
        od[1] = if1.d; oc[1] = if1.carry;
        od[2] = if2.d; oc[2] = if2.carry;
        od[3] = if3.d; oc[3] = if3.carry;
        od[4] = if4.d; oc[4] = if4.carry;
        od[5] = if5.d; oc[5] = if5.carry;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("u%0d_d", i), 32'(od[i]), 32'(cnt[i]));
            check($sformatf("u%0d_carry", i), 32'(oc[i]), 32'(exp_c[i]));
        end
    endtask

    task automatic cycle();
        apply();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int hc;

        // Reset dominates inc and clr.
        rstn = 1'b0;
        set_all(1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("rst_u0_d", 32'(if0.d), 32'd0);
            check("rst_u5_carry", 32'(if5.carry), 32'd0);
        end
        rstn = 1'b1;
        set_all(1'b0, 1'b0);
        cycle();
        check("post_rst_u0_d", 32'(if0.d), 32'd0);

        // MAX=9 level mode: 1..9,0,1,2 with carry only on the wrap.
        inc_v[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("u0_seq_d", 32'(if0.d), 32'(k % 10));
            check("u0_seq_carry", 32'(if0.carry), 32'(k == 10));
        end
        inc_v[0] = 1'b0;

        // MAX=5 edge mode: a held inc counts once, then three single pulses.
        inc_v[1] = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("u1_held_d", 32'(if1.d), 32'd1);
        inc_v[1] = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            inc_v[1] = 1'b1; cycle();
            inc_v[1] = 1'b0; cycle();
            check("u1_pulse_d", 32'(if1.d), 32'(k + 2));
            check("u1_pulse_carry", 32'(if1.carry), 32'd0);
        end

        // MAX=3: clr beats a wrapping increment.
        inc_v[2] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("u2_at_max", 32'(if2.d), 32'd3);
        clr_v[2] = 1'b1;
        cycle();
        check("u2_clr_d", 32'(if2.d), 32'd0);
        check("u2_clr_carry", 32'(if2.carry), 32'd0);
        clr_v[2] = 1'b0;
        cycle();
        check("u2_after_clr_d", 32'(if2.d), 32'd1);
        inc_v[2] = 1'b0;
        cycle();

        // Cascade 9/2: 30 counts, high digit lags the low wrap by one cycle.
        hc = 0;
        inc_v[3] = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            if (k == 31) inc_v[3] = 1'b0;
            cycle();
            if (if4.carry === 1'b1) hc++;
            check("casc_low", 32'(if3.d), 32'((k > 30 ? 30 : k) % 10));
            check("casc_high", 32'(if4.d), 32'(((k - 1) / 10) % 3));
        end
        check("casc_high_carries", 32'(hc), 32'd1);

        // MAX=0: every event is a wrap.
        inc_v[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("u5_d", 32'(if5.d), 32'd0);
            check("u5_carry", 32'(if5.carry), 32'd1);
        end
        inc_v[5] = 1'b0;
        cycle();
        check("u5_idle_carry", 32'(if5.carry), 32'd0);

        // Random traffic with sporadic clears and resets.
        for (int k = 0; k < 400; k++) begin
            rstn = ($urandom_range(63) != 0);
            for (int i = 0; i < 6; i++) begin
                inc_v[i] = 1'($urandom_range(1));
                clr_v[i] = ($urandom_range(15) == 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
